// File: rtl/sobel_stream_2d.sv
// sobel_stream_2d: row-parallel 3x3 Sobel edge filter with valid/ready flow control.
// Each accepted beat is one image row. The block keeps the two previous rows
// and emits one filtered row of SIZE-2 pixels once three rows of a frame are held.
module sobel_stream_2d #(
    parameter int SIZE   = 100,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] arr_in [SIZE-1:0],
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] thresh,
    output logic [DATA_W-1:0] arr_out [SIZE-3:0],
    output logic              out_valid,
    output logic              out_sof,
    input  logic              out_ready
);

    // Internal arithmetic width: |Gx|,|Gy| <= 4*(2^DATA_W-1) and their sum
    // fits in DATA_W+3 bits, so one extra bit leaves room for the sign of a difference.
    localparam int W = DATA_W + 4;
    localparam logic [W-1:0] PIX_MAX = {4'b0000, {DATA_W{1'b1}}};

    localparam logic [1:0] MODE_MAG    = 2'd0;
    localparam logic [1:0] MODE_GX     = 2'd1;
    localparam logic [1:0] MODE_GY     = 2'd2;
    localparam logic [1:0] MODE_THRESH = 2'd3;

    logic [DATA_W-1:0] top_row [SIZE-1:0];
    logic [DATA_W-1:0] mid_row [SIZE-1:0];
    logic [DATA_W-1:0] px_res  [SIZE-3:0];
    logic [1:0]        row_count;
    logic              frame_first;
    logic              accept;
    logic              produce;

    function automatic logic [W-1:0] ext(input logic [DATA_W-1:0] p);
        return {4'b0000, p};
    endfunction

    function automatic logic [DATA_W-1:0] sat(input logic [W-1:0] x);
        return (x > PIX_MAX) ? {DATA_W{1'b1}} : x[DATA_W-1:0];
    endfunction

    // Absolute difference of two weighted sums; the subtraction wraps modulo 2^W
    // and the top bit then acts as the sign.
    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] pos, input logic [W-1:0] neg);
        logic [W-1:0] d;
        d = pos - neg;
        return d[W-1] ? (~d + 1'b1) : d;
    endfunction

    // One output pixel from the 3x3 neighbourhood (centre pixel carries no weight).
    function automatic logic [DATA_W-1:0] sobel_px(
        input logic [DATA_W-1:0] t0, input logic [DATA_W-1:0] t1, input logic [DATA_W-1:0] t2,
        input logic [DATA_W-1:0] m0, input logic [DATA_W-1:0] m2,
        input logic [DATA_W-1:0] b0, input logic [DATA_W-1:0] b1, input logic [DATA_W-1:0] b2,
        input logic [1:0] md, input logic [DATA_W-1:0] th
    );
        logic [W-1:0]      ax;
        logic [W-1:0]      ay;
        logic [DATA_W-1:0] sat_mag;
        logic [DATA_W-1:0] res;
        ax = abs_diff(ext(t2) + (ext(m2) << 1) + ext(b2), ext(t0) + (ext(m0) << 1) + ext(b0));
        ay = abs_diff(ext(b0) + (ext(b1) << 1) + ext(b2), ext(t0) + (ext(t1) << 1) + ext(t2));
        sat_mag = sat(ax + ay);
        case (md)
            MODE_MAG:    res = sat_mag;
            MODE_GX:     res = sat(ax);
            MODE_GY:     res = sat(ay);
            MODE_THRESH: res = (sat_mag >= th) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            default:     res = sat_mag;
        endcase
        return res;
    endfunction

    // Single output register: a new row may enter whenever that register is empty or draining.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // A row produces output only as the third (or later) row of its frame.
    assign produce  = accept && !in_sof && (row_count == 2'd2);

    // Filter every interior column in parallel; columns 0 and SIZE-1 have no output.
    for (genvar j = 0; j < SIZE - 2; j++) begin : g_col
        assign px_res[j] = sobel_px(top_row[j], top_row[j+1], top_row[j+2],
                                    mid_row[j], mid_row[j+2],
                                    arr_in[j], arr_in[j+1], arr_in[j+2],
                                    mode, thresh);
    end

    // Row window: shift the stored rows up on every accepted row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the row buffers are reset explicitly because stale rows must
            // never leak into the first outputs after reset; this costs reset fan-out.
            for (int c = 0; c < SIZE; c++) begin
                top_row[c] <= '0;
                mid_row[c] <= '0;
            end
        end else if (accept) begin
            // NOTE: non-blocking assignments make top_row take the old mid_row,
            // not the row being written into mid_row in the same edge.
            for (int c = 0; c < SIZE; c++) begin
                top_row[c] <= mid_row[c];
                mid_row[c] <= arr_in[c];
            end
        end
    end

    // Frame tracking and output register with hold-under-backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_count   <= 2'd0;
            frame_first <= 1'b1;
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            for (int j = 0; j < SIZE - 2; j++) begin
                arr_out[j] <= '0;
            end
        end else if (accept) begin
            if (in_sof) begin
                row_count   <= 2'd1;
                frame_first <= 1'b1;
            end else begin
                row_count <= (row_count == 2'd2) ? 2'd2 : row_count + 2'd1;
                if (produce) begin
                    frame_first <= 1'b0;
                end
            end
            out_valid <= produce;
            out_sof   <= produce && frame_first;
            if (produce) begin
                for (int j = 0; j < SIZE - 2; j++) begin
                    arr_out[j] <= px_res[j];
                end
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_stream_2d.sv
// Testbench for sobel_stream_2d (SIZE=8, DATA_W=8): directed rows, expected
// rows queued at issue time, a monitor pops and compares on every output transfer.
module tb_sobel_stream_2d;

    localparam int SIZE   = 8;
    localparam int DATA_W = 8;

    typedef logic [7:0] row_t [SIZE-1:0];
    typedef logic [7:0] out_t [SIZE-3:0];
    typedef struct packed {
        logic        sof;
        logic [47:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    row_t       arr_in;
    logic       in_valid;
    logic       in_sof;
    logic       in_ready;
    logic [1:0] mode;
    logic [7:0] thresh;
    out_t       arr_out;
    logic       out_valid;
    logic       out_sof;
    logic       out_ready;

    exp_t sb[$];
    int   xfer_cyc[$];
    int   cyc;
    int   n_cmp;
    int   n_err;

    sobel_stream_2d #(.SIZE(SIZE), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arr_in    (arr_in),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .mode      (mode),
        .thresh    (thresh),
        .arr_out   (arr_out),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] pack_out(input out_t a);
        logic [47:0] p;
        for (int j = 0; j < SIZE - 2; j++) p[j*8 +: 8] = a[j];
        return p;
    endfunction

    function automatic row_t flat_row(input logic [7:0] v);
        row_t r;
        for (int c = 0; c < SIZE; c++) r[c] = v;
        return r;
    endfunction

    // Columns 0..3 dark, 4..7 bright.
    function automatic row_t edge_row();
        row_t r;
        for (int c = 0; c < SIZE; c++) r[c] = (c >= 4) ? 8'd255 : 8'd0;
        return r;
    endfunction

    // Output column j is 255 where mask[j] is set, 0 elsewhere.
    function automatic logic [47:0] exp_mask(input logic [5:0] m);
        logic [47:0] p;
        for (int j = 0; j < SIZE - 2; j++) p[j*8 +: 8] = m[j] ? 8'd255 : 8'd0;
        return p;
    endfunction

    function automatic logic [47:0] exp_const(input logic [7:0] v);
        logic [47:0] p;
        for (int j = 0; j < SIZE - 2; j++) p[j*8 +: 8] = v;
        return p;
    endfunction

    function automatic exp_t mk_exp(input logic sof, input logic [47:0] data);
        exp_t e;
        e.sof  = sof;
        e.data = data;
        return e;
    endfunction

    // Present one row and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send_row(input row_t r, input logic sof, input logic [1:0] m, input logic [7:0] th);
        bit ok;
        ok       = 1'b0;
        arr_in   = r;
        in_sof   = sof;
        mode     = m;
        thresh   = th;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Monitor: every output transfer is compared against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                xfer_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_sof", 64'(out_sof), 64'(e.sof));
                    check("out_data", 64'(pack_out(arr_out)), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        mode      = 2'd0;
        thresh    = 8'd0;
        out_ready = 1'b1;
        arr_in    = flat_row(8'd0);

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sof", 64'(out_sof), 64'd0);
        check("rst_arr_out", 64'(pack_out(arr_out)), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Vertical edge, mode 0
        send_row(edge_row(), 1'b1, 2'd0, 8'd0);
        send_row(edge_row(), 1'b0, 2'd0, 8'd0);
        check("no_out_row2", 64'(out_valid), 64'd0);
        sb.push_back(mk_exp(1'b1, exp_mask(6'b001100)));
        send_row(edge_row(), 1'b0, 2'd0, 8'd0);
        check("latency_valid", 64'(out_valid), 64'd1);
        check("latency_sof", 64'(out_sof), 64'd1);
        sb.push_back(mk_exp(1'b0, exp_mask(6'b001100)));
        send_row(edge_row(), 1'b0, 2'd0, 8'd0);

        // Horizontal ramp: each window spans a step of 20 top-to-bottom, Gy=80, Gx=0
        send_row(flat_row(8'd10), 1'b1, 2'd2, 8'd0);
        send_row(flat_row(8'd20), 1'b0, 2'd2, 8'd0);
        sb.push_back(mk_exp(1'b1, exp_const(8'd80)));
        send_row(flat_row(8'd30), 1'b0, 2'd2, 8'd0);
        sb.push_back(mk_exp(1'b0, exp_const(8'd0)));
        send_row(flat_row(8'd40), 1'b0, 2'd1, 8'd0);
        sb.push_back(mk_exp(1'b0, exp_const(8'd255)));
        send_row(flat_row(8'd50), 1'b0, 2'd3, 8'd80);
        sb.push_back(mk_exp(1'b0, exp_const(8'd0)));
        send_row(flat_row(8'd60), 1'b0, 2'd3, 8'd81);

        // Backpressure: output held for 5 cycles, pending row accepted on release
        send_row(edge_row(), 1'b1, 2'd0, 8'd0);
        send_row(edge_row(), 1'b0, 2'd0, 8'd0);
        out_ready = 1'b0;
        sb.push_back(mk_exp(1'b1, exp_mask(6'b001100)));
        send_row(edge_row(), 1'b0, 2'd0, 8'd0);
        sb.push_back(mk_exp(1'b0, exp_mask(6'b111100)));
        fork
            send_row(flat_row(8'd0), 1'b0, 2'd0, 8'd0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_out_valid", 64'(out_valid), 64'd1);
                    check("stall_arr_out", 64'(pack_out(arr_out)), 64'(exp_mask(6'b001100)));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("pending_valid", 64'(out_valid), 64'd1);
        check("pending_data", 64'(pack_out(arr_out)), 64'(exp_mask(6'b111100)));

        // Frame restart: frame A bright, frame B dark; B output must ignore A rows
        send_row(flat_row(8'd255), 1'b1, 2'd0, 8'd0);
        send_row(flat_row(8'd255), 1'b0, 2'd0, 8'd0);
        sb.push_back(mk_exp(1'b1, exp_const(8'd0)));
        send_row(flat_row(8'd255), 1'b0, 2'd0, 8'd0);
        sb.push_back(mk_exp(1'b0, exp_const(8'd0)));
        send_row(flat_row(8'd255), 1'b0, 2'd0, 8'd0);
        send_row(flat_row(8'd0), 1'b1, 2'd0, 8'd0);
        check("restart_no_out1", 64'(out_valid), 64'd0);
        send_row(flat_row(8'd0), 1'b0, 2'd0, 8'd0);
        check("restart_no_out2", 64'(out_valid), 64'd0);
        sb.push_back(mk_exp(1'b1, exp_const(8'd0)));
        send_row(flat_row(8'd0), 1'b0, 2'd0, 8'd0);

        // Flat image, continuous valid: three outputs on consecutive cycles
        repeat (2) @(negedge clk);
        xfer_cyc.delete();
        @(posedge clk);
        #1;
        send_row(flat_row(8'd100), 1'b1, 2'd0, 8'd0);
        send_row(flat_row(8'd100), 1'b0, 2'd0, 8'd0);
        sb.push_back(mk_exp(1'b1, exp_const(8'd0)));
        send_row(flat_row(8'd100), 1'b0, 2'd0, 8'd0);
        sb.push_back(mk_exp(1'b0, exp_const(8'd0)));
        send_row(flat_row(8'd100), 1'b0, 2'd0, 8'd0);
        sb.push_back(mk_exp(1'b0, exp_const(8'd0)));
        send_row(flat_row(8'd100), 1'b0, 2'd0, 8'd0);
        repeat (3) @(negedge clk);
        check("flat_xfer_count", 64'(xfer_cyc.size()), 64'd3);
        if (xfer_cyc.size() == 3) begin
            check("flat_no_bubble1", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd1);
            check("flat_no_bubble2", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'd1);
        end

        // Reset mid-stream while an output is held
        @(posedge clk);
        #1;
        send_row(edge_row(), 1'b1, 2'd0, 8'd0);
        send_row(edge_row(), 1'b0, 2'd0, 8'd0);
        out_ready = 1'b0;
        send_row(edge_row(), 1'b0, 2'd0, 8'd0);
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_sof", 64'(out_sof), 64'd0);
        check("midrst_arr_out", 64'(pack_out(arr_out)), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("midrst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send_row(edge_row(), 1'b0, 2'd0, 8'd0);
        send_row(edge_row(), 1'b0, 2'd0, 8'd0);
        check("post_reset_no_out", 64'(out_valid), 64'd0);
        sb.push_back(mk_exp(1'b1, exp_mask(6'b001100)));
        send_row(edge_row(), 1'b0, 2'd0, 8'd0);

        repeat (4) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
